// File: rtl/pc_update_unit_pkg.sv
// Shared types and constants for the PC update unit: FSM state encoding,
// next-address select encodings, reset/trap vector defaults and the branch
// offset helper.
package pc_update_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'b00,
    SEL_JUMP   = 2'b01,
    SEL_BRANCH = 2'b10,
    SEL_REG    = 2'b11
  } addr_sel_t;

  localparam logic [31:0] RESETPC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] TRAPPC_DEFAULT  = 32'h0000_0080;

  // Word offset to byte offset: sign-extend and scale by 4.
  function automatic logic [31:0] branch_byte_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_update_unit_if.sv
// Bundle of decision/target inputs, fetch handshake and PC outputs between
// the branch/jump control side (master) and the PC update unit (slave).
interface pc_update_unit_if;
  logic [1:0]  addrdecision;
  logic        jpc;
  logic [25:0] jumptarget;
  logic [15:0] branchimm;
  logic [31:0] regtarget;
  logic [31:0] memtarget;
  logic        imemready;
  logic        instrdone;
  logic [31:0] pc;
  logic [31:0] pcplus4;
  logic        fetchreq;
  logic [31:0] epc;
  logic        trap;

  modport master (
    output addrdecision, jpc, jumptarget, branchimm, regtarget, memtarget,
           imemready, instrdone,
    input  pc, pcplus4, fetchreq, epc, trap
  );

  modport slave (
    input  addrdecision, jpc, jumptarget, branchimm, regtarget, memtarget,
           imemready, instrdone,
    output pc, pcplus4, fetchreq, epc, trap
  );
endinterface

// File: rtl/pc_update_unit_next_pc_mux.sv
// Combinational next-PC selection. Only the branch/memory and register
// sources can yield a misaligned target; sequential and jump targets inherit
// the alignment of pc.
module pc_update_unit_next_pc_mux
  import pc_update_unit_pkg::*;
(
  input  logic [31:0] i_pcplus4,
  input  logic [1:0]  i_addrdecision,
  input  logic        i_jpc,
  input  logic [25:0] i_jumptarget,
  input  logic [15:0] i_branchimm,
  input  logic [31:0] i_regtarget,
  input  logic [31:0] i_memtarget,
  output logic [31:0] o_target,
  output logic        o_misaligned
);

  // Select the candidate next PC from the decoded address source.
  always_comb begin
    o_target = i_pcplus4;
    case (addr_sel_t'(i_addrdecision))
      SEL_SEQ:    o_target = i_pcplus4;
      SEL_JUMP:   o_target = {i_pcplus4[31:28], i_jumptarget, 2'b00};
      SEL_BRANCH: o_target = i_jpc ? i_memtarget
                                   : i_pcplus4 + branch_byte_offset(i_branchimm);
      SEL_REG:    o_target = i_regtarget;
      default:    o_target = i_pcplus4;
    endcase
  end

  assign o_misaligned = |o_target[1:0];

endmodule

// File: rtl/pc_update_unit.sv
// Program-counter register and fetch sequencer. Paces fetch with a
// request/complete handshake, commits the selected next PC when the current
// instruction completes, and redirects misaligned targets to TRAPPC.
//
// state | meaning
// IDLE  | just out of reset; fetch starts on the next edge
// FETCH | fetchreq high, waiting for imemready
// EXEC  | instruction executing, waiting for instrdone to commit next PC
module pc_update_unit
  import pc_update_unit_pkg::*;
#(
  parameter logic [31:0] RESETPC = RESETPC_DEFAULT,
  parameter logic [31:0] TRAPPC  = TRAPPC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  pc_update_unit_if.slave   bus
);

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_epc;
  logic        r_trap;

  logic [31:0] w_pcplus4;
  logic [31:0] w_target;
  logic        w_misaligned;

  assign w_pcplus4 = r_pc + 32'd4;

  pc_update_unit_next_pc_mux u_next_pc_mux (
    .i_pcplus4      (w_pcplus4),
    .i_addrdecision (bus.addrdecision),
    .i_jpc          (bus.jpc),
    .i_jumptarget   (bus.jumptarget),
    .i_branchimm    (bus.branchimm),
    .i_regtarget    (bus.regtarget),
    .i_memtarget    (bus.memtarget),
    .o_target       (w_target),
    .o_misaligned   (w_misaligned)
  );

  // Fetch/execute sequencing with PC commit and trap capture on instrdone.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_pc    <= RESETPC;
      r_epc   <= 32'd0;
      r_trap  <= 1'b0;
    end else begin
      r_trap <= 1'b0;
      case (r_state)
        IDLE: r_state <= FETCH;
        FETCH: begin
          if (bus.imemready) r_state <= EXEC;
        end
        EXEC: begin
          if (bus.instrdone) begin
            r_state <= FETCH;
            if (w_misaligned) begin
              r_pc   <= TRAPPC;
              r_epc  <= w_target;
              r_trap <= 1'b1;
            end else begin
              r_pc <= w_target;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.pc       = r_pc;
  assign bus.pcplus4  = w_pcplus4;
  assign bus.fetchreq = (r_state == FETCH);
  assign bus.epc      = r_epc;
  assign bus.trap     = r_trap;

endmodule

// File: tb/tb_pc_update_unit.sv
// Scoreboard bench for pc_update_unit: the driver pushes the expected state of
// each new fetch into a queue at commit time; a negedge monitor pops and
// compares whenever a new fetch begins, and checks PC stability while fetch
// stalls and that trap never lasts beyond the first fetch cycle.
module tb_pc_update_unit;
  import pc_update_unit_pkg::*;

  localparam logic [31:0] RESETPC = 32'h0000_0000;
  localparam logic [31:0] TRAPPC  = 32'h0000_0080;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pc_update_unit_if bus();

  pc_update_unit #(.RESETPC(RESETPC), .TRAPPC(TRAPPC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic        trap;
    logic [31:0] epc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_pc;
  logic [31:0] m_epc;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference next-PC from the architectural rules, plain modulo-2^32 math.
  function automatic logic [31:0] model_next(input logic [1:0] sel, input logic jpc,
                                             input logic [25:0] jt, input logic [15:0] bi,
                                             input logic [31:0] rt, input logic [31:0] mt);
    logic [31:0] p4;
    int          off;
    p4  = m_pc + 32'd4;
    off = int'($signed(bi));
    case (sel)
      2'd0:    return p4;
      2'd1:    return (p4 & 32'hF000_0000) | (32'(jt) * 32'd4);
      2'd2:    return jpc ? mt : p4 + 32'(off * 4);
      default: return rt;
    endcase
  endfunction

  task automatic noise_ctrl();
    bus.addrdecision = 2'($urandom_range(0, 3));
    bus.jpc          = 1'($urandom_range(0, 1));
    bus.jumptarget   = 26'($urandom);
    bus.branchimm    = 16'($urandom);
    bus.regtarget    = $urandom;
    bus.memtarget    = $urandom;
  endtask

  task automatic wait_fetch(output bit found);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.fetchreq === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!found) begin
      n_checks++;
      n_errors++;
      $display("FAIL fetch_timeout: fetchreq=%b after 10 cycles, expected 1", bus.fetchreq);
    end
  endtask

  // One full instruction: optional fetch stall, execute wait, then commit.
  task automatic do_instr(input logic [1:0] sel, input logic jpc, input logic [25:0] jt,
                          input logic [15:0] bi, input logic [31:0] rt, input logic [31:0] mt,
                          input int stall, input bit spurious);
    bit          found;
    int          ns;
    int          nw;
    logic [31:0] t;
    wait_fetch(found);
    if (!found) return;
    ns = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
    for (int k = 0; k < ns; k++) begin
      bus.imemready = 1'b0;
      bus.instrdone = spurious | 1'($urandom_range(0, 1));
      noise_ctrl();
      @(posedge clk); #1;
    end
    bus.imemready = 1'b1;
    bus.instrdone = 1'b0;
    @(posedge clk); #1;
    nw = int'($urandom_range(0, 2));
    for (int k = 0; k < nw; k++) begin
      bus.imemready = 1'($urandom_range(0, 1));
      bus.instrdone = 1'b0;
      noise_ctrl();
      @(posedge clk); #1;
    end
    bus.addrdecision = sel;
    bus.jpc          = jpc;
    bus.jumptarget   = jt;
    bus.branchimm    = bi;
    bus.regtarget    = rt;
    bus.memtarget    = mt;
    bus.imemready    = 1'($urandom_range(0, 1));
    bus.instrdone    = 1'b1;
    t = model_next(sel, jpc, jt, bi, rt, mt);
    if (t % 4 != 0) begin
      exp_q.push_back('{pc: TRAPPC, trap: 1'b1, epc: t});
      m_pc  = TRAPPC;
      m_epc = t;
    end else begin
      exp_q.push_back('{pc: t, trap: 1'b0, epc: m_epc});
      m_pc = t;
    end
    @(posedge clk); #1;
    bus.instrdone = 1'b0;
    bus.imemready = 1'b0;
    noise_ctrl();
  endtask

  // Monitor: compare on each new fetch, check stability while fetch stalls.
  logic        prev_fetch = 1'b0;
  logic [31:0] last_pc = 32'd0;
  always @(negedge clk) begin
    if (reset) begin
      prev_fetch = 1'b0;
    end else begin
      if (bus.fetchreq && !prev_fetch) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_fetch: fetch started at pc %h, expected no fetch", bus.pc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check32("fetch_pc", bus.pc, e.pc);
          check32("fetch_pcplus4", bus.pcplus4, e.pc + 32'd4);
          check32("fetch_trap", {31'd0, bus.trap}, {31'd0, e.trap});
          check32("fetch_epc", bus.epc, e.epc);
        end
      end else if (bus.fetchreq) begin
        check32("stall_pc_stable", bus.pc, last_pc);
        check32("trap_one_cycle", {31'd0, bus.trap}, 32'd0);
      end else begin
        check32("trap_outside_fetch", {31'd0, bus.trap}, 32'd0);
      end
      prev_fetch = bus.fetchreq;
      last_pc    = bus.pc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          found;
    logic [31:0] rt;
    logic [1:0]  sel;
    bus.addrdecision = 2'd0;
    bus.jpc          = 1'b0;
    bus.jumptarget   = 26'd0;
    bus.branchimm    = 16'd0;
    bus.regtarget    = 32'd0;
    bus.memtarget    = 32'd0;
    bus.imemready    = 1'b0;
    bus.instrdone    = 1'b0;
    reset            = 1'b1;

    // Reset held two cycles, then one IDLE cycle before fetch.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check32("reset_pc", bus.pc, RESETPC);
    check32("reset_fetchreq", {31'd0, bus.fetchreq}, 32'd0);
    check32("reset_epc", bus.epc, 32'd0);
    check32("reset_trap", {31'd0, bus.trap}, 32'd0);
    m_pc  = RESETPC;
    m_epc = 32'd0;
    exp_q.push_back('{pc: RESETPC, trap: 1'b0, epc: 32'd0});
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check32("idle_cycle_fetchreq", {31'd0, bus.fetchreq}, 32'd0);
    @(posedge clk); #1;

    // Directed cases; first one stalls 3 cycles with spurious instrdone.
    do_instr(2'd3, 1'b0, 26'd0, 16'd0, 32'h0000_0040, 32'd0, 3, 1'b1);
    do_instr(2'd0, 1'b0, 26'd0, 16'd0, 32'd0, 32'd0, -1, 1'b0);
    do_instr(2'd3, 1'b0, 26'd0, 16'd0, 32'hFFFF_FFFC, 32'd0, 0, 1'b0);
    do_instr(2'd0, 1'b0, 26'd0, 16'd0, 32'd0, 32'd0, -1, 1'b0);
    do_instr(2'd3, 1'b0, 26'd0, 16'd0, 32'h1000_0010, 32'd0, 0, 1'b0);
    do_instr(2'd1, 1'b0, 26'h0000_100, 16'd0, 32'd0, 32'd0, -1, 1'b0);
    do_instr(2'd3, 1'b0, 26'd0, 16'd0, 32'h0000_0100, 32'd0, 0, 1'b0);
    do_instr(2'd2, 1'b0, 26'd0, 16'hFFFE, 32'd0, 32'd0, -1, 1'b0);
    do_instr(2'd2, 1'b1, 26'd0, 16'd0, 32'd0, 32'h0000_0200, -1, 1'b0);
    do_instr(2'd3, 1'b0, 26'd0, 16'd0, 32'h0000_0300, 32'd0, -1, 1'b0);
    do_instr(2'd3, 1'b0, 26'd0, 16'd0, 32'h0000_0302, 32'd0, 0, 1'b0);
    do_instr(2'd0, 1'b0, 26'd0, 16'd0, 32'd0, 32'd0, 2, 1'b0);

    // Reset during EXEC together with instrdone: reset wins.
    wait_fetch(found);
    if (found) begin
      bus.imemready = 1'b1;
      @(posedge clk); #1;
      bus.imemready    = 1'b0;
      bus.addrdecision = 2'd3;
      bus.regtarget    = 32'h0000_0502;
      bus.instrdone    = 1'b1;
      reset            = 1'b1;
      @(posedge clk); #1;
      check32("midreset_pc", bus.pc, RESETPC);
      check32("midreset_epc", bus.epc, 32'd0);
      check32("midreset_trap", {31'd0, bus.trap}, 32'd0);
      check32("midreset_fetchreq", {31'd0, bus.fetchreq}, 32'd0);
      exp_q.delete();
      m_pc  = RESETPC;
      m_epc = 32'd0;
      exp_q.push_back('{pc: RESETPC, trap: 1'b0, epc: 32'd0});
      reset         = 1'b0;
      bus.instrdone = 1'b0;
      @(negedge clk);
      check32("midreset_idle_fetchreq", {31'd0, bus.fetchreq}, 32'd0);
      @(posedge clk); #1;
    end

    // Randomized instruction stream; about a quarter of register/memory
    // targets are misaligned.
    for (int n = 0; n < 60; n++) begin
      sel = 2'($urandom_range(0, 3));
      rt  = {$urandom() >> 2, 2'b00};
      if ($urandom_range(0, 3) == 0) rt = rt + 32'($urandom_range(1, 3));
      do_instr(sel, 1'($urandom_range(0, 1)), 26'($urandom), 16'($urandom),
               rt, $urandom_range(0, 3) == 0 ? rt + 32'd1 : rt + 32'h40, -1, 1'b0);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_update_unit.md
# pc_update_unit

Program-counter register and fetch sequencer placed directly downstream of the branch/jump decision logic. Consumes the 2-bit address-select decision and the `jpc` flag, builds the next fetch address, and paces instruction fetch with a two-phase request/complete handshake. Also provides the link value (`pcplus4`) to the register-write path and traps misaligned targets to a fixed vector.

## Interface
- `RESETPC`, default 32'h0000_0000: PC value loaded on reset.
- `TRAPPC`, default 32'h0000_0080: PC loaded when a computed target is misaligned.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `addrdecision`  in  2  next-address select from branch/jump control:
  - 00 sequential
  - 01 jump
  - 10 branch, or memory target when `jpc`
  - 11 register target
- `jpc`  in  1  qualifies `addrdecision`=10 as memory-supplied target.
- `jumptarget`  in  26  instruction index field.
- `branchimm`  in  16  signed branch offset, in words.
- `regtarget`  in  32  register-file target value.
- `memtarget`  in  32  data-memory target value.
- `imemready`  in  1  instruction memory has delivered the word at `pc`.
- `instrdone`  in  1  current instruction completed; commit next PC.
- `pc`  out  32  current fetch address.
- `pcplus4`  out  32  `pc`+4, combinational; link value.
- `fetchreq`  out  1  fetch request for `pc`.
- `epc`  out  32  last misaligned target captured.
- `trap`  out  1  one-cycle pulse on trap redirect.

## Operation
- States:
  - IDLE: entered by reset; moves to FETCH unconditionally on the next edge.
  - FETCH: `fetchreq`=1. On `imemready`=1, moves to EXEC.
  - EXEC: `fetchreq`=0. On `instrdone`=1, loads the next PC and moves to FETCH.
- `instrdone` is ignored outside EXEC. `imemready` is ignored outside FETCH.
- Next-PC sources:
  - 00: `pcplus4`.
  - 01: {`pcplus4`[31:28], `jumptarget`, 2'b00}.
  - 10, `jpc`=0: `pcplus4` + (sign-extended `branchimm` << 2).
  - 10, `jpc`=1: `memtarget`.
  - 11: `regtarget`.
- Arithmetic is modulo 2^32. Wrap-around is silent: 32'hFFFF_FFFC + 4 = 0.
- Misaligned target: if the selected next PC has nonzero bits [1:0], then on the commit edge:
  - `pc` ← `TRAPPC`
  - `epc` ← the selected value
  - `trap` = 1 for exactly the following cycle
  - state → FETCH as normal.
- Sources 00 and 01 are always aligned (given an aligned `pc`). Only sources 10 and 11 can trap.
- `addrdecision`, `jpc` and the target inputs are sampled only on the commit edge. They may change freely at other times.

## Timing
- Reset values, applied on any edge with `reset`=1 (including mid-instruction):
  - `pc`=`RESETPC`, `epc`=0, `trap`=0, state=IDLE, `fetchreq`=0.
  - Reset wins over simultaneous `imemready` or `instrdone`.
- `fetchreq` is decoded from registered state, so it is glitch-free.
- Minimum instruction period is 2 cycles: FETCH with `imemready` high, then EXEC with `instrdone` high.
- New `pc` is visible the cycle after the commit edge. `fetchreq` rises in that same cycle.
- `pcplus4` follows `pc` with zero latency.
- `trap` is registered and coincides with the first FETCH cycle at `TRAPPC`.

## Structure
- Shared package holds:
  - state encoding constants IDLE=2'd0, FETCH=2'd1, EXEC=2'd2;
  - address-select encodings SEL_SEQ, SEL_JUMP, SEL_BRANCH, SEL_REG;
  - `RESETPC`/`TRAPPC` defaults.
- One natural sub-module: `next_pc_mux`. It is combinational and produces the selected target plus a misaligned flag.
- The top level holds the FSM, the `pc`/`epc`/`trap` registers and the `pcplus4` adder.

## Test plan
- Reset/startup: hold `reset` 2 cycles → `pc`=0, `fetchreq`=0. Release → IDLE one cycle, then `fetchreq`=1 with `pc`=0.
- Sequential and wrap:
  - `pc`=0x40, `addrdecision`=00, commit → `pc`=0x44.
  - Preload 0xFFFF_FFFC, commit → `pc`=0x0, no trap.
- Jump and branch:
  - `pc`=0x1000_0010, jump with `jumptarget`=26'h0000_100 → `pc`=0x1000_0400.
  - Branch with `branchimm`=16'hFFFE from `pc`=0x100 → `pc`=0xFC.
- jpc vs register:
  - `addrdecision`=10, `jpc`=1, `memtarget`=0x200 → `pc`=0x200.
  - `addrdecision`=11, `regtarget`=0x300 → `pc`=0x300.
- Trap: `addrdecision`=11, `regtarget`=0x302 → `pc`=0x80, `epc`=0x302, `trap` high exactly one cycle.
- Handshake stalls and spurious inputs:
  - `imemready` low 3 cycles → state stays FETCH, `pc` stable.
  - `instrdone` pulsed during FETCH → no PC change.
  - `reset` asserted in EXEC alongside `instrdone` → `pc`=`RESETPC`.
